// File: rtl/pes_elc_scheduler.sv
// SCAN-style call scheduler for the single-car elevator: latches calls, picks the next floor
// in the sweep direction, then dwells with the door open. Optional move timeout: PES_ELC_SCHED_TIMEOUT_EN.
module pes_elc_scheduler #(
   parameter int unsigned DWELL_CYCLES = 4,
   parameter int unsigned MOVE_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] call_req,
   input  logic [7:0] car_floor,
   input  logic       car_complete,
   input  logic       car_door_alert,
   input  logic       car_weight_alert,
   output logic [7:0] target_floor,
   output logic       target_valid,
   output logic [7:0] pending,
   output logic       sweep_up,
   output logic       door_open,
   output logic       hold,
   output logic       floor_err,
   output logic       fault
);

   localparam int unsigned NF = 8;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_MOVE, S_DWELL, S_HOLD} state_t;

   state_t        state;
   logic [CW-1:0] dwell_cnt;
   logic [NF-1:0] served;

   function automatic logic [NF-1:0] lowest_bit(input logic [NF-1:0] v);
      lowest_bit = v & (~v + NF'(1));
   endfunction

   function automatic logic [NF-1:0] highest_bit(input logic [NF-1:0] v);
      logic [NF-1:0] r;
      r = '0;
      for (int i = 0; i < NF; i++)
         if (v[i]) r = NF'(1) << i;
      highest_bit = r;
   endfunction

   logic          alert;
   logic          floor_ok;
   logic          floor_hit;
   logic [NF-1:0] sel_tgt;
   logic          sel_flip;
   logic          dwell_reload;
   logic [NF-1:0] clr_mask;
   logic [NF-1:0] req_eff;

   // Next-target selection: nearest pending floor ahead, else reverse and take nearest behind.
   always_comb begin
      logic [NF-1:0] below_set;
      logic [NF-1:0] above_set;
      alert     = car_door_alert | car_weight_alert;
      floor_ok  = (car_floor != '0) && ((car_floor & (car_floor - NF'(1))) == '0);
      floor_hit = (pending & car_floor) != '0;
      below_set = pending & (car_floor - NF'(1));
      above_set = pending & ~((car_floor - NF'(1)) | car_floor);
      sel_tgt   = '0;
      sel_flip  = 1'b0;
      if (sweep_up) begin
         if (above_set != '0) sel_tgt = lowest_bit(above_set);
         else begin
            sel_tgt  = highest_bit(below_set);
            sel_flip = 1'b1;
         end
      end else begin
         if (below_set != '0) sel_tgt = highest_bit(below_set);
         else begin
            sel_tgt  = lowest_bit(above_set);
            sel_flip = 1'b1;
         end
      end
   end

   // A call on the served floor during dwell restarts the dwell instead of becoming pending.
   always_comb begin
      dwell_reload = (state == S_DWELL) && ((call_req & served) != '0);
      req_eff      = (state == S_DWELL) ? (call_req & ~served) : call_req;
      clr_mask     = '0;
      if (state == S_DWELL && !alert && !dwell_reload && dwell_cnt == '0)
         clr_mask = served;
   end

`ifdef PES_ELC_SCHED_TIMEOUT_EN
   localparam int unsigned MW = 7;
   localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TIMEOUT - 1);
   logic [MW-1:0] move_cnt;
`else
   logic unused_cfg;
   assign unused_cfg = ^32'(MOVE_TIMEOUT);
   assign fault      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         pending      <= '0;
         target_floor <= '0;
         target_valid <= 1'b0;
         sweep_up     <= 1'b1;
         door_open    <= 1'b0;
         hold         <= 1'b0;
         floor_err    <= 1'b0;
         dwell_cnt    <= '0;
         served       <= '0;
`ifdef PES_ELC_SCHED_TIMEOUT_EN
         fault        <= 1'b0;
         move_cnt     <= '0;
`endif
      end else begin
         pending <= (pending | req_eff) & ~clr_mask;
         case (state)
            S_IDLE: begin
`ifdef PES_ELC_SCHED_TIMEOUT_EN
               if (!fault && pending != '0) state <= S_SELECT;
`else
               if (pending != '0) state <= S_SELECT;
`endif
            end
            S_SELECT: begin
               if (alert) begin
                  hold         <= 1'b1;
                  target_valid <= 1'b0;
                  state        <= S_HOLD;
               end else if (!floor_ok) begin
                  floor_err <= 1'b1;
               end else begin
                  floor_err <= 1'b0;
                  if (pending == '0) begin
                     state <= S_IDLE;
                  end else if (floor_hit) begin
                     served    <= car_floor;
                     door_open <= 1'b1;
                     dwell_cnt <= DWELL_LOAD;
                     state     <= S_DWELL;
                  end else begin
                     target_floor <= sel_tgt;
                     target_valid <= 1'b1;
                     sweep_up     <= sweep_up ^ sel_flip;
                     state        <= S_MOVE;
`ifdef PES_ELC_SCHED_TIMEOUT_EN
                     move_cnt     <= '0;
`endif
                  end
               end
            end
            S_MOVE: begin
               if (alert) begin
                  hold         <= 1'b1;
                  target_valid <= 1'b0;
                  state        <= S_HOLD;
               end else if (car_complete && car_floor == target_floor) begin
                  target_valid <= 1'b0;
                  served       <= target_floor;
                  door_open    <= 1'b1;
                  dwell_cnt    <= DWELL_LOAD;
                  state        <= S_DWELL;
               end
`ifdef PES_ELC_SCHED_TIMEOUT_EN
               else if (move_cnt == MOVE_LAST) begin
                  fault        <= 1'b1;
                  target_valid <= 1'b0;
                  state        <= S_IDLE;
               end else begin
                  move_cnt <= move_cnt + MW'(1);
               end
`endif
            end
            S_DWELL: begin
               if (alert) begin
                  hold         <= 1'b1;
                  target_valid <= 1'b0;
                  state        <= S_HOLD;
               end else if (dwell_reload) begin
                  dwell_cnt <= DWELL_LOAD;
               end else if (dwell_cnt == '0) begin
                  door_open <= 1'b0;
                  state     <= S_SELECT;
               end else begin
                  dwell_cnt <= dwell_cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (!alert) begin
                  hold      <= 1'b0;
                  door_open <= 1'b0;
                  dwell_cnt <= '0;
                  state     <= S_SELECT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pes_elc_scheduler.sv
// Directed bench for pes_elc_scheduler (default build, move timeout disabled).
module tb_pes_elc_scheduler;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] call_req;
   logic [7:0] car_floor;
   logic       car_complete;
   logic       car_door_alert;
   logic       car_weight_alert;
   logic [7:0] target_floor;
   logic       target_valid;
   logic [7:0] pending;
   logic       sweep_up;
   logic       door_open;
   logic       hold;
   logic       floor_err;
   logic       fault;

   int total = 0;
   int bad   = 0;

   pes_elc_scheduler #(.DWELL_CYCLES(4), .MOVE_TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .call_req(call_req), .car_floor(car_floor),
      .car_complete(car_complete), .car_door_alert(car_door_alert),
      .car_weight_alert(car_weight_alert), .target_floor(target_floor),
      .target_valid(target_valid), .pending(pending), .sweep_up(sweep_up),
      .door_open(door_open), .hold(hold), .floor_err(floor_err), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int  door_cnt;
      logic tv_seen;
      reset = 1'b0; call_req = '0; car_floor = 8'h01; car_complete = 1'b0;
      car_door_alert = 1'b0; car_weight_alert = 1'b0;
      step(); step();
      chk("rst_pending", pending, 8'h00);
      chk("rst_target", target_floor, 8'h00);
      chk("rst_tvalid", 8'(target_valid), 8'h0);
      chk("rst_sweep", 8'(sweep_up), 8'h1);
      chk("rst_door", 8'(door_open), 8'h0);
      chk("rst_hold", 8'(hold), 8'h0);
      chk("rst_ferr", 8'(floor_err), 8'h0);
      chk("rst_fault", 8'(fault), 8'h0);
      reset = 1'b1;
      step();

      // single call upward from floor 0 to floor 4
      call_req = 8'h10; step(); call_req = '0;
      chk("t2_pending", pending, 8'h10);
      step();
      chk("t2_tv_early", 8'(target_valid), 8'h0);
      step();
      chk("t2_target", target_floor, 8'h10);
      chk("t2_tvalid", 8'(target_valid), 8'h1);
      step();
      car_complete = 1'b1; step();
      chk("t2_stale_tv", 8'(target_valid), 8'h1);
      chk("t2_stale_door", 8'(door_open), 8'h0);
      car_floor = 8'h10; step(); car_complete = 1'b0;
      chk("t2_arr_tv", 8'(target_valid), 8'h0);
      door_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!door_open) break;
         door_cnt++;
         step();
      end
      chk("t2_door_cycles", 8'(door_cnt), 8'd4);
      chk("t2_pending_clr", pending, 8'h00);
      step();

      // sweep up serves 0x40 first, then reverses to 0x01
      car_floor = 8'h08; call_req = 8'h41; step(); call_req = '0;
      chk("t3_pending", pending, 8'h41);
      step(); step();
      chk("t3_target_up", target_floor, 8'h40);
      chk("t3_sweep_up", 8'(sweep_up), 8'h1);
      car_floor = 8'h40; car_complete = 1'b1; step(); car_complete = 1'b0;
      chk("t3_door", 8'(door_open), 8'h1);
      step(); step(); step(); step();
      chk("t3_door_off", 8'(door_open), 8'h0);
      chk("t3_pending_left", pending, 8'h01);
      step();
      chk("t3_target_dn", target_floor, 8'h01);
      chk("t3_sweep_dn", 8'(sweep_up), 8'h0);
      chk("t3_tvalid", 8'(target_valid), 8'h1);
      car_floor = 8'h01; car_complete = 1'b1; step(); car_complete = 1'b0;
      step(); step(); step(); step();
      chk("t3_pending_clr", pending, 8'h00);
      step();

      // call at the car's own floor: direct dwell, re-call restarts the dwell
      car_floor = 8'h04; call_req = 8'h04; step(); call_req = '0;
      tv_seen = 1'b0;
      step(); step();
      tv_seen = tv_seen | target_valid;
      chk("t4_door_direct", 8'(door_open), 8'h1);
      door_cnt = 1;
      step();
      tv_seen = tv_seen | target_valid;
      if (door_open) door_cnt++;
      call_req = 8'h04; step(); call_req = '0;
      tv_seen = tv_seen | target_valid;
      if (door_open) door_cnt++;
      for (int i = 0; i < 20; i++) begin
         step();
         tv_seen = tv_seen | target_valid;
         if (!door_open) break;
         door_cnt++;
      end
      chk("t4_door_cycles", 8'(door_cnt), 8'd6);
      chk("t4_tv_never", 8'(tv_seen), 8'h0);
      chk("t4_pending_clr", pending, 8'h00);
      step();

      // weight alert interrupts a move to 0x80; re-selected afterwards
      call_req = 8'h80; step(); call_req = '0;
      step(); step();
      chk("t5_target", target_floor, 8'h80);
      chk("t5_tvalid", 8'(target_valid), 8'h1);
      step();
      car_weight_alert = 1'b1; step();
      chk("t5_hold", 8'(hold), 8'h1);
      chk("t5_hold_tv", 8'(target_valid), 8'h0);
      call_req = 8'h02; step(); call_req = '0;
      step(); step(); step();
      chk("t5_hold_still", 8'(hold), 8'h1);
      chk("t5_hold_pending", pending, 8'h82);
      car_weight_alert = 1'b0; step();
      chk("t5_unhold", 8'(hold), 8'h0);
      step();
      chk("t5_retarget", target_floor, 8'h80);
      chk("t5_retv", 8'(target_valid), 8'h1);

      // arrive at 0x80, then bad car_floor at the following selection
      car_floor = 8'h80; car_complete = 1'b1; step(); car_complete = 1'b0;
      step(); step(); step(); step();
      chk("t6_pending", pending, 8'h02);
      car_floor = 8'h06; step();
      chk("t6_floor_err", 8'(floor_err), 8'h1);
      chk("t6_no_tv", 8'(target_valid), 8'h0);
      car_floor = 8'h80; step();
      chk("t6_floor_ok", 8'(floor_err), 8'h0);
      chk("t6_target", target_floor, 8'h02);
      chk("t6_sweep", 8'(sweep_up), 8'h0);
      car_floor = 8'h02; car_complete = 1'b1; step(); car_complete = 1'b0;
      step(); step(); step(); step(); step();

      // alerts in IDLE are ignored
      car_door_alert = 1'b1; step(); step();
      chk("t7_idle_hold", 8'(hold), 8'h0);
      car_door_alert = 1'b0;

      // reset mid-move with pending 0x24
      car_floor = 8'h01; call_req = 8'h24; step(); call_req = '0;
      step(); step();
      chk("t8_pending", pending, 8'h24);
      chk("t8_target", target_floor, 8'h04);
      reset = 1'b0; #1;
      chk("t8_async_pending", pending, 8'h00);
      step();
      chk("t8_rst_tv", 8'(target_valid), 8'h0);
      chk("t8_rst_target", target_floor, 8'h00);
      chk("t8_rst_sweep", 8'(sweep_up), 8'h1);
      reset = 1'b1; step(); step();
      chk("t8_idle_tv", 8'(target_valid), 8'h0);
      chk("t8_fault", 8'(fault), 8'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pes_elc_scheduler.md
Name: pes_elc_scheduler

Overview:
- SCAN-style call scheduler for the single-car elevator datapath.
- Latches hall/car call buttons for 8 one-hot floors into a pending set and picks the next target floor in the current sweep direction.
- Drives the car's request floor, waits for arrival, then holds the door open for a dwell period.
- Sits between the call-button panel and the elevator car block; consumes the car's current-floor, complete and alert outputs.

Parameters:
- DWELL_CYCLES, 4, door-open dwell length in clk cycles (1..255).
- MOVE_TIMEOUT, 64, max cycles in MOVE before fault (used only with the optional feature).

Ports:
- clk  input  1  system clock (low-frequency).
- reset  input  1  asynchronous, active-low reset.
- call_req  input  8  one-hot-per-bit call buttons; any number of bits may be set; a bit held high counts as one call.
- car_floor  input  8  car's current floor, one-hot.
- car_complete  input  1  car reports it is stopped at its requested floor.
- car_door_alert  input  1  door-held-open alert from car.
- car_weight_alert  input  1  overweight alert from car.
- target_floor  output  8  one-hot request floor driven to car.
- target_valid  output  1  target_floor is live.
- pending  output  8  current pending-call set.
- sweep_up  output  1  sweep direction: 1 = up (higher bit index), 0 = down.
- door_open  output  1  high during dwell.
- hold  output  1  scheduler paused by an alert.
- floor_err  output  1  car_floor not one-hot when a selection was attempted.
- fault  output  1  move timeout (sticky until reset; optional feature only).

Behaviour:
- Reset values, asynchronous on reset low: pending=0, target_floor=0, target_valid=0, sweep_up=1, door_open=0, hold=0, floor_err=0, fault=0, dwell counter=0, state=IDLE.
- All outputs registered; all inputs sampled on posedge clk.
- Pending: every cycle, pending <= (pending | call_req) & ~clr_mask.
  - clr_mask = served floor on the last DWELL cycle, else 0.
  - Clear wins over a same-cycle set on the served floor.
- States: IDLE, SELECT, MOVE, DWELL, HOLD.
- IDLE: go to SELECT when pending != 0. The new call is visible in pending 1 cycle after call_req; SELECT follows on the next cycle.
- SELECT (1 cycle):
  - If car_floor is not one-hot: set floor_err (sticky until the next good SELECT), stay in SELECT.
  - If pending & car_floor != 0: go to DWELL directly with no move.
  - Else, if sweep_up: target = lowest pending bit above car_floor. If none, flip sweep_up and take the highest pending bit below.
  - Mirror rule when sweep_up=0.
  - If pending == 0: go to IDLE.
  - On a chosen target: target_floor <= target, target_valid <= 1, go to MOVE.
- MOVE:
  - target_floor and target_valid are held stable.
  - Arrival = car_complete && car_floor == target_floor. On arrival: target_valid <= 0, go to DWELL.
  - car_complete with car_floor != target_floor is ignored (stale completion).
  - New calls received in MOVE do not retarget mid-move.
- DWELL:
  - door_open=1; counter counts DWELL_CYCLES-1 down to 0.
  - A new call_req on the car_floor bit during DWELL reloads the counter and is absorbed (not left pending).
  - At 0: clear the served floor bit, door_open <= 0, go to SELECT.
- HOLD:
  - Entered from SELECT, MOVE or DWELL when car_door_alert || car_weight_alert. hold=1, target_valid=0, door_open unchanged.
  - Pending keeps accumulating.
  - When both alerts are low: hold <= 0, go to SELECT with the dwell counter reset. An interrupted move re-selects from scratch.
  - Alerts in IDLE are ignored.
- Reset mid-operation: immediate return to reset values; pending calls are lost.

Optional Feature:
- Macro: PES_ELC_SCHED_TIMEOUT_EN.
- Defined:
  - A 7-bit move counter runs in MOVE.
  - When it reaches MOVE_TIMEOUT without arrival: fault <= 1, target_valid <= 0, go to IDLE.
  - While fault=1, the scheduler stays in IDLE; pending still accumulates.
- Undefined:
  - No counter; fault is tied to 0.
  - MOVE waits indefinitely.

Test Plan:
- Reset low mid-MOVE with pending=8'h24 -> next edge all outputs at reset values, pending=0, state IDLE.
- car_floor=8'h01, call_req=8'h10 one cycle -> pending=8'h10; target_floor=8'h10, target_valid=1 two cycles later. car_complete with car_floor=8'h10 -> door_open high 4 cycles, pending=0.
- car_floor=8'h08, sweep_up=1, pending=8'h41 -> serves 8'h40 first. Next SELECT: sweep_up flips to 0, target 8'h01.
- car_floor=8'h04, call_req=8'h04 in IDLE -> DWELL directly, target_valid never asserts. Repeat call_req=8'h04 at dwell cycle 2 -> dwell restarts, total 6 door_open cycles.
- In MOVE to 8'h80, car_weight_alert=1 for 5 cycles -> hold=1, target_valid=0. Alert low -> SELECT re-issues 8'h80.
- With PES_ELC_SCHED_TIMEOUT_EN and MOVE_TIMEOUT=64, no car_complete -> fault=1 exactly 64 cycles after MOVE entry; new call_req=8'h02 is pending but not served.
